// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector issue queue: issue-state encoding,
// entry field widths and default sizing.
package vec_pkg;

  localparam int VEC_DEPTH_DEFAULT         = 8;
  localparam int VEC_FREEZE_MARGIN_DEFAULT = 2;
  localparam int VEC_INST_W_DEFAULT        = 32;
  localparam int VEC_SV_W                  = 1;
  localparam int VEC_SCALAR_W              = 32;

  typedef enum logic [1:0] {
    IQ_IDLE      = 2'd0,
    IQ_ISSUE     = 2'd1,
    IQ_WAIT_DONE = 2'd2
  } iq_state_e;

  // Two-bit counter increment that sticks at 3.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/vec_iq_fifo.sv
// Synchronous FIFO with push/pop/count and no bypass: a pushed word is only
// visible at the head from the cycle after the push.
module vec_iq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 65,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/vector_issue_queue.sv
// Vector issue queue: buffers EX-stage vector ops and issues them one at a time
// to the VXU, driving the fetch throttle. Optional macro: VEC_IQ_OVF_CHECK_EN.
module vector_issue_queue
  import vec_pkg::*;
#(
  parameter int DEPTH         = VEC_DEPTH_DEFAULT,
  parameter int INST_W        = VEC_INST_W_DEFAULT,
  parameter int FREEZE_MARGIN = VEC_FREEZE_MARGIN_DEFAULT,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    vec_valid_in,
  input  logic [INST_W-1:0]       vec_inst_in,
  input  logic                    vec_sv_in,
  input  logic [VEC_SCALAR_W-1:0] vec_scalar_in,
  input  logic                    flush_in,
  output logic                    exu_valid_out,
  output logic [INST_W-1:0]       exu_inst_out,
  output logic                    exu_sv_out,
  output logic [VEC_SCALAR_W-1:0] exu_scalar_out,
  input  logic                    exu_ready_in,
  input  logic                    exu_done_in,
  output logic                    Vector__Stall,
  output logic                    Vector__freeze,
  output logic [1:0]              Vector_release_counter,
  output logic                    ovf_err,
  output logic [1:0]              dbg_state_o,
  output logic [CW-1:0]           dbg_count_o
);

  localparam int ENTRY_W = INST_W + VEC_SV_W + VEC_SCALAR_W;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FREEZE_MARGIN);

  iq_state_e          state_q, state_d;
  logic [1:0]         rel_q, rel_d;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] head;
  logic               stall;

  // Valid/ready: exu_valid_out rises in ISSUE and the head payload is held
  // stable until exu_ready_in is seen high on a rising edge; that edge pops.
  assign push = vec_valid_in & ~flush_in & ~fifo_full;

  vec_iq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push),
    .data_i  ({vec_inst_in, vec_sv_in, vec_scalar_in}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IQ_IDLE;
      rel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IQ_IDLE:      if (!fifo_empty) state_d = IQ_ISSUE;
      IQ_ISSUE: begin
        if (exu_ready_in) begin
          pop     = 1'b1;
          state_d = IQ_WAIT_DONE;
        end
      end
      IQ_WAIT_DONE: if (exu_done_in) state_d = IQ_IDLE;
      default:      state_d = IQ_IDLE;
    endcase
  end

  assign stall = (fifo_count != '0) | (state_q != IQ_IDLE);

  // Stall is registered state, so the clear lands one cycle after it falls.
  always_comb begin
    rel_d = rel_q;
    if (!stall) begin
      rel_d = 2'd0;
    end else if (state_q == IQ_WAIT_DONE && exu_done_in) begin
      rel_d = sat_inc2(rel_q);
    end
  end

  assign exu_valid_out  = (state_q == IQ_ISSUE);
  assign exu_inst_out   = exu_valid_out ? head[ENTRY_W-1 -: INST_W] : '0;
  assign exu_sv_out     = exu_valid_out ? head[VEC_SCALAR_W] : 1'b0;
  assign exu_scalar_out = exu_valid_out ? head[VEC_SCALAR_W-1:0] : '0;

  assign Vector__Stall          = stall;
  assign Vector__freeze         = (DEPTH_C - fifo_count) <= MARGIN_C;
  assign Vector_release_counter = rel_q;
  assign dbg_state_o            = state_q;
  assign dbg_count_o            = fifo_count;

`ifdef VEC_IQ_OVF_CHECK_EN
  logic drop;
  logic ovf_q;

  assign drop = vec_valid_in & ~flush_in & fifo_full;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  always @(posedge CLK) begin
    if (RST_N && drop) $error("vector_issue_queue: enqueue dropped on full queue");
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_vector_issue_queue.sv
// Directed bench for vector_issue_queue: single op, fill/drop, backpressure,
// release-counter saturation, reset mid-operation and flush.
module tb_vector_issue_queue;

  logic        CLK;
  logic        RST_N;
  logic        vec_valid_in;
  logic [31:0] vec_inst_in;
  logic        vec_sv_in;
  logic [31:0] vec_scalar_in;
  logic        flush_in;
  logic        exu_valid_out;
  logic [31:0] exu_inst_out;
  logic        exu_sv_out;
  logic [31:0] exu_scalar_out;
  logic        exu_ready_in;
  logic        exu_done_in;
  logic        Vector__Stall;
  logic        Vector__freeze;
  logic [1:0]  Vector_release_counter;
  logic        ovf_err;
  logic [1:0]  dbg_state_o;
  logic [3:0]  dbg_count_o;

  int checks = 0;
  int errors = 0;

`ifdef VEC_IQ_OVF_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  vector_issue_queue dut (
    .CLK                    (CLK),
    .RST_N                  (RST_N),
    .vec_valid_in           (vec_valid_in),
    .vec_inst_in            (vec_inst_in),
    .vec_sv_in              (vec_sv_in),
    .vec_scalar_in          (vec_scalar_in),
    .flush_in               (flush_in),
    .exu_valid_out          (exu_valid_out),
    .exu_inst_out           (exu_inst_out),
    .exu_sv_out             (exu_sv_out),
    .exu_scalar_out         (exu_scalar_out),
    .exu_ready_in           (exu_ready_in),
    .exu_done_in            (exu_done_in),
    .Vector__Stall          (Vector__Stall),
    .Vector__freeze         (Vector__freeze),
    .Vector_release_counter (Vector_release_counter),
    .ovf_err                (ovf_err),
    .dbg_state_o            (dbg_state_o),
    .dbg_count_o            (dbg_count_o)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [31:0] inst, input logic sv, input logic [31:0] sc, input logic fl);
    vec_valid_in  = 1'b1;
    vec_inst_in   = inst;
    vec_sv_in     = sv;
    vec_scalar_in = sc;
    flush_in      = fl;
    tick();
    vec_valid_in  = 1'b0;
    flush_in      = 1'b0;
  endtask

  task automatic pulse_done();
    exu_done_in = 1'b1;
    tick();
    exu_done_in = 1'b0;
  endtask

  task automatic accept();
    exu_ready_in = 1'b1;
    tick();
    exu_ready_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_valid"},  {31'd0, exu_valid_out}, 32'd0);
    chk({pfx, "_inst"},   exu_inst_out, 32'd0);
    chk({pfx, "_sv"},     {31'd0, exu_sv_out}, 32'd0);
    chk({pfx, "_scalar"}, exu_scalar_out, 32'd0);
    chk({pfx, "_stall"},  {31'd0, Vector__Stall}, 32'd0);
    chk({pfx, "_freeze"}, {31'd0, Vector__freeze}, 32'd0);
    chk({pfx, "_rel"},    {30'd0, Vector_release_counter}, 32'd0);
    chk({pfx, "_ovf"},    {31'd0, ovf_err}, 32'd0);
    chk({pfx, "_state"},  {30'd0, dbg_state_o}, 32'd0);
    chk({pfx, "_count"},  {28'd0, dbg_count_o}, 32'd0);
  endtask

  logic [3:0] fill_cnt [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
  logic       fill_frz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] sat_rel  [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    RST_N = 1'b0; vec_valid_in = 1'b0; vec_inst_in = '0; vec_sv_in = 1'b0;
    vec_scalar_in = '0; flush_in = 1'b0; exu_ready_in = 1'b0; exu_done_in = 1'b0;
    #12;
    chk_reset_outputs("rst");
    @(negedge CLK);
    RST_N = 1'b1;

    // single vv op
    exu_ready_in = 1'b1;
    enq(32'h0000_0057, 1'b0, 32'h0, 1'b0);
    chk("t1_count", {28'd0, dbg_count_o}, 32'd1);
    chk("t1_stall", {31'd0, Vector__Stall}, 32'd1);
    chk("t1_valid_early", {31'd0, exu_valid_out}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, exu_valid_out}, 32'd1);
    chk("t1_inst", exu_inst_out, 32'h57);
    chk("t1_sv", {31'd0, exu_sv_out}, 32'd0);
    tick();
    exu_ready_in = 1'b0;
    chk("t1_state_wait", {30'd0, dbg_state_o}, 32'd2);
    chk("t1_count_pop", {28'd0, dbg_count_o}, 32'd0);
    chk("t1_valid_drop", {31'd0, exu_valid_out}, 32'd0);
    chk("t1_stall_wait", {31'd0, Vector__Stall}, 32'd1);
    tick();
    tick();
    chk("t1_rel_before", {30'd0, Vector_release_counter}, 32'd0);
    pulse_done();
    chk("t1_rel_one", {30'd0, Vector_release_counter}, 32'd1);
    chk("t1_stall_fall", {31'd0, Vector__Stall}, 32'd0);
    chk("t1_state_idle", {30'd0, dbg_state_o}, 32'd0);
    tick();
    chk("t1_rel_clear", {30'd0, Vector_release_counter}, 32'd0);

    // fill with the VXU not ready; ninth enqueue is dropped
    for (int i = 0; i < 9; i++) begin
      enq(32'h0000_0100 + 32'(i), 1'(i & 1), 32'hA000_0100 + 32'(i), 1'b0);
      chk($sformatf("fill%0d_count", i), {28'd0, dbg_count_o}, {28'd0, fill_cnt[i]});
      chk($sformatf("fill%0d_freeze", i), {31'd0, Vector__freeze}, {31'd0, fill_frz[i]});
    end
    chk("fill_ovf", {31'd0, ovf_err}, {31'd0, EXP_OVF});
    chk("fill_head", exu_inst_out, 32'h100);

    // backpressure: payload holds while ready is low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), {31'd0, exu_valid_out}, 32'd1);
      chk($sformatf("bp%0d_inst", i), exu_inst_out, 32'h100);
      chk($sformatf("bp%0d_scalar", i), exu_scalar_out, 32'hA000_0100);
      chk($sformatf("bp%0d_count", i), {28'd0, dbg_count_o}, 32'd8);
    end
    accept();
    chk("bp_state_wait", {30'd0, dbg_state_o}, 32'd2);
    chk("bp_count_pop", {28'd0, dbg_count_o}, 32'd7);
    chk("bp_valid_drop", {31'd0, exu_valid_out}, 32'd0);
    chk("bp_freeze", {31'd0, Vector__freeze}, 32'd1);

    // four retirements under continuous stall saturate the counter
    for (int k = 0; k < 4; k++) begin
      pulse_done();
      chk($sformatf("sat%0d_rel", k), {30'd0, Vector_release_counter}, {30'd0, sat_rel[k]});
      chk($sformatf("sat%0d_stall", k), {31'd0, Vector__Stall}, 32'd1);
      tick();
      chk($sformatf("sat%0d_inst", k), exu_inst_out, 32'h101 + 32'(k));
      chk($sformatf("sat%0d_sv", k), {31'd0, exu_sv_out}, {31'd0, 1'((k + 1) & 1)});
      chk($sformatf("sat%0d_scalar", k), exu_scalar_out, 32'hA000_0101 + 32'(k));
      accept();
      chk($sformatf("sat%0d_state", k), {30'd0, dbg_state_o}, 32'd2);
    end
    chk("sat_count_left", {28'd0, dbg_count_o}, 32'd3);

    // asynchronous reset in WAIT_DONE with three entries queued
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    pulse_done();
    chk("post_rst_state", {30'd0, dbg_state_o}, 32'd0);
    chk("post_rst_stall", {31'd0, Vector__Stall}, 32'd0);
    chk("post_rst_rel", {30'd0, Vector_release_counter}, 32'd0);
    chk("post_rst_count", {28'd0, dbg_count_o}, 32'd0);

    // flush kills only the same-cycle enqueue
    enq(32'h0000_0200, 1'b0, 32'h0, 1'b0);
    enq(32'h0000_0201, 1'b1, 32'h0000_5555, 1'b0);
    enq(32'h0000_02FF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("fl_count", {28'd0, dbg_count_o}, 32'd2);
    chk("fl_state", {30'd0, dbg_state_o}, 32'd1);
    chk("fl_inst0", exu_inst_out, 32'h200);
    accept();
    chk("fl_count1", {28'd0, dbg_count_o}, 32'd1);
    pulse_done();
    chk("fl_rel1", {30'd0, Vector_release_counter}, 32'd1);
    tick();
    chk("fl_inst1", exu_inst_out, 32'h201);
    chk("fl_sv1", {31'd0, exu_sv_out}, 32'd1);
    chk("fl_scalar1", exu_scalar_out, 32'h0000_5555);
    accept();
    chk("fl_count0", {28'd0, dbg_count_o}, 32'd0);
    pulse_done();
    chk("fl_stall_fall", {31'd0, Vector__Stall}, 32'd0);
    chk("fl_rel2", {30'd0, Vector_release_counter}, 32'd2);
    tick();
    chk("fl_rel_clear", {30'd0, Vector_release_counter}, 32'd0);
    chk("fl_valid_idle", {31'd0, exu_valid_out}, 32'd0);
    chk("fl_inst_idle", exu_inst_out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
